// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Two-master round-robin arbiter in front of one single-port on-chip RAM. The RAM is an
// altsyncram with a registered address and an unregistered q. Both Nios II data masters
// (m0_*, m1_*) share the RAM slave port (mem_*).
//
// Build option:
//   ARB_LOCK_EN  When defined, a master that is accepted with mN_lock=1 keeps the RAM to
//                itself until it drops mN_lock. This supports atomic read-modify-write
//                sequences. When undefined, mN_lock is ignored and arbitration is pure
//                round-robin.
//
// Timing summary:
//   - Grant is combinational within the cycle. An access is accepted on the clock edge
//     where mN_read|mN_write is high and mN_waitrequest is low.
//   - Read data is valid on mem_readdata one cycle after acceptance. It is registered into
//     mN_readdata, and mN_readdatavalid pulses in the following cycle. Accept-to-valid is
//     therefore two cycles.
//   - A request with read and write both high is treated as a write only. It returns no
//     data.
// ---------------------------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    // requester 0
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    // requester 1
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    // RAM slave port
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    // -----------------------------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------------------------
    logic req0;
    logic req1;
    logic rd_only0;
    logic rd_only1;

    // A request with read and write both high is a write, so only a pure read returns data.
    always_comb begin
        req0     = m0_read | m0_write;
        req1     = m1_read | m1_write;
        rd_only0 = m0_read & ~m0_write;
        rd_only1 = m1_read & ~m1_write;
    end

    // -----------------------------------------------------------------------------------------
    // Round-robin state
    // -----------------------------------------------------------------------------------------
    // last_grant_q: 0 = m0 won the most recent accepted access, 1 = m1 won it.
    // It resets to 1 so that m0 wins the first tie.
    logic last_grant_q;
    logic last_grant_d;

    logic rr_gnt0;
    logic rr_gnt1;

    // Round-robin choice: a lone requester wins; on a tie, the master that did not win
    // last time wins.
    always_comb begin
        rr_gnt0 = req0 & (~req1 | last_grant_q);
        rr_gnt1 = req1 & (~req0 | ~last_grant_q);
    end

    // Grants before reset gating. These are driven by the lock logic when it is present,
    // otherwise by the round-robin choice alone.
    logic raw_gnt0;
    logic raw_gnt1;

`ifdef ARB_LOCK_EN
    // -----------------------------------------------------------------------------------------
    // Lock FSM: one master may pin the grant for an atomic sequence
    // -----------------------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StNone = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } lock_state_e;

    lock_state_e lock_q;
    lock_state_e lock_d;

    // Lock state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= StNone;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Grant selection and lock next-state.
    // While a master owns the lock, the other master is always stalled. The owner releases
    // the lock as soon as it presents mN_lock=0, whether or not it is also requesting.
    always_comb begin
        lock_d   = lock_q;
        raw_gnt0 = 1'b0;
        raw_gnt1 = 1'b0;
        unique case (lock_q)
            StOwn0: begin
                raw_gnt0 = req0;
                if (!m0_lock) begin
                    lock_d = StNone;
                end
            end
            StOwn1: begin
                raw_gnt1 = req1;
                if (!m1_lock) begin
                    lock_d = StNone;
                end
            end
            default: begin
                raw_gnt0 = rr_gnt0;
                raw_gnt1 = rr_gnt1;
                if (raw_gnt0 && m0_lock) begin
                    lock_d = StOwn0;
                end else if (raw_gnt1 && m1_lock) begin
                    lock_d = StOwn1;
                end
            end
        endcase
    end
`else
    // The lock inputs have no function in this build.
    logic unused_lock;

    // Pure round-robin grant.
    always_comb begin
        raw_gnt0    = rr_gnt0;
        raw_gnt1    = rr_gnt1;
        unused_lock = m0_lock ^ m1_lock;
    end
`endif

    // -----------------------------------------------------------------------------------------
    // Grant, stall and RAM port mux
    // -----------------------------------------------------------------------------------------
    logic gnt0;
    logic gnt1;

    // No grant is issued while reset is asserted, so both masters see waitrequest=1 and the
    // RAM sees no access.
    always_comb begin
        gnt0 = raw_gnt0 & reset_n;
        gnt1 = raw_gnt1 & reset_n;
    end

    // Stall every master that is not the current winner.
    always_comb begin
        m0_waitrequest = ~gnt0;
        m1_waitrequest = ~gnt1;
    end

    // Steer the winner onto the RAM. m0 is the default path when neither master is granted.
    always_comb begin
        mem_address    = gnt1 ? m1_address    : m0_address;
        mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
        mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
        mem_chipselect = gnt0 | gnt1;
        mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
        mem_clken      = reset_n;
    end

    // -----------------------------------------------------------------------------------------
    // Round-robin pointer update
    // -----------------------------------------------------------------------------------------
    // The pointer moves only on an accepted access. An idle cycle leaves it alone.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Read return pipeline
    // -----------------------------------------------------------------------------------------
    // Bit N of rd_pend_q marks that master N had a pure read accepted on the previous edge.
    // The RAM therefore presents that read's data on mem_readdata this cycle.
    logic [1:0]        rd_pend_q;
    logic [1:0]        rd_pend_d;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Mark accepted pure reads.
    always_comb begin
        rd_pend_d = {gnt1 & rd_only1, gnt0 & rd_only0};
    end

    // Pending-read flags. Reset drops any in-flight read, so no valid pulse follows it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 2'b00;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    // Capture RAM data for the master that owns the pending read, and raise its one-cycle
    // valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= rd_pend_q;
            if (rd_pend_q[0]) begin
                rdata0_q <= mem_readdata;
            end
            if (rd_pend_q[1]) begin
                rdata1_q <= mem_readdata;
            end
        end
    end

    // Registered read-return outputs. readdata holds its value between valid pulses.
    always_comb begin
        m0_readdata      = rdata0_q;
        m1_readdata      = rdata1_q;
        m0_readdatavalid = rvalid_q[0];
        m1_readdatavalid = rvalid_q[1];
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter.
// Expected read data goes into per-master queues when a read is accepted. A monitor pops
// an entry and compares it when the matching readdatavalid pulse arrives. Compile with
// +define+ARB_LOCK_EN to exercise the lock build.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address,    m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read,       m1_read;
    logic              m0_write,      m1_write;
    logic [DATA_W-1:0] m0_writedata,  m1_writedata;
    logic              m0_lock,       m1_lock;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata,   m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // RAM model: registered address, unregistered q, byte-lane writes at the clock edge.
    logic [DATA_W-1:0] ram [256];
    logic [ADDR_W-1:0] ram_aq;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            ram_aq <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_aq];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              q0[$];
    exp_t              q1[$];
    int                errors  = 0;
    int                checks  = 0;
    int                cyc     = 0;
    int                vcount0 = 0;
    int                vcount1 = 0;
    logic              exp_last;
    logic [DATA_W-1:0] ref_mem [256];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: each valid pulse must match the oldest expected read of its master.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset_n) begin
            if (m0_readdatavalid) begin
                vcount0++;
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL m0_unexpected_valid: got data %h, required no pulse", m0_readdata);
                end else begin
                    e = q0.pop_front();
                    if (m0_readdata !== e.data) begin
                        errors++;
                        $display("FAIL m0_rdata: got %h, required %h", m0_readdata, e.data);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL m0_latency: pulse at cycle %0d, required %0d", cyc, e.due);
                    end
                end
            end
            if (m1_readdatavalid) begin
                vcount1++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL m1_unexpected_valid: got data %h, required no pulse", m1_readdata);
                end else begin
                    e = q1.pop_front();
                    if (m1_readdata !== e.data) begin
                        errors++;
                        $display("FAIL m1_rdata: got %h, required %h", m1_readdata, e.data);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL m1_latency: pulse at cycle %0d, required %0d", cyc, e.due);
                    end
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                 input logic [BE_W-1:0] be,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic idle_all();
        m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0;
        m0_writedata = '0; m0_lock = 1'b0;
        m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = '0; m1_lock = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single write by master m with no competition: it must be granted at once.
    task automatic wr(input int m, input logic [7:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        idle_all();
        if (m == 0) begin
            m0_address = a; m0_byteenable = be; m0_writedata = d; m0_write = 1'b1;
        end else begin
            m1_address = a; m1_byteenable = be; m1_writedata = d; m1_write = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (((m == 0) ? m0_waitrequest : m1_waitrequest) !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant m%0d: waitrequest got 1, required 0", m);
        end
        checks++;
        if (mem_write !== 1'b1 || mem_address !== a || mem_byteenable !== be) begin
            errors++;
            $display("FAIL wr_mem_port m%0d: write=%b addr=%h be=%h, required 1 %h %h",
                     m, mem_write, mem_address, mem_byteenable, a, be);
        end
        ref_mem[a] = merge(ref_mem[a], be, d);
        exp_last = (m == 1);
        next_cycle();
        idle_all();
    endtask

    // Single read by master m with no competition; the expected data goes on the scoreboard.
    task automatic rd(input int m, input logic [7:0] a, input logic [31:0] expd);
        exp_t e;
        idle_all();
        if (m == 0) begin
            m0_address = a; m0_byteenable = 4'hF; m0_read = 1'b1;
        end else begin
            m1_address = a; m1_byteenable = 4'hF; m1_read = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (((m == 0) ? m0_waitrequest : m1_waitrequest) !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant m%0d: waitrequest got 1, required 0", m);
        end else begin
            e.data = expd;
            e.due  = cyc + 2;
            if (m == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        exp_last = (m == 1);
        next_cycle();
        idle_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_last = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        int v0;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_waitrequest: got %b%b, required 11", m0_waitrequest, m1_waitrequest);
        end
        checks++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 ||
            m0_readdata !== '0 || m1_readdata !== '0) begin
            errors++;
            $display("FAIL reset_readport: valid=%b%b data=%h/%h, required 00 0/0",
                     m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata);
        end
        checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: cs=%b wr=%b clken=%b, required 000",
                     mem_chipselect, mem_write, mem_clken);
        end
        // A read accepted just before reset is asserted must never return data.
        reset_n = 1'b1;
        exp_last = 1'b1;
        next_cycle();
        m0_read = 1'b1;
        m0_address = 8'h00;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_preread_grant: waitrequest got %b, required 0", m0_waitrequest);
        end
        checks++;
        if (mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL clken_active: got %b, required 1", mem_clken);
        end
        next_cycle();
        idle_all();
        reset_n = 1'b0;
        v0 = vcount0;
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b0 || m0_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_midread: valid=%b wait=%b, required 0 1",
                     m0_readdatavalid, m0_waitrequest);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_last = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (vcount0 != v0) begin
            errors++;
            $display("FAIL reset_dropped_read: pulses got %0d, required 0", vcount0 - v0);
        end
        next_cycle();
    endtask

    task automatic test_single();
        int v1;
        v1 = vcount1;
        wr(0, 8'h05, 4'hF, 32'hDEADBEEF);
        rd(0, 8'h05, 32'hDEADBEEF);
        repeat (4) @(negedge clk);
        checks++;
        if (vcount1 != v1) begin
            errors++;
            $display("FAIL single_m1_quiet: m1 pulses got %0d, required 0", vcount1 - v1);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        int   i0, i1, w;
        exp_t e;
        for (int i = 0; i < 8; i++) wr(0, 8'h40 + 8'(i), 4'hF, 32'hC0DE0000 + i);
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 10; k++) begin
            m0_read = 1'b1; m0_byteenable = 4'hF; m0_address = 8'h40 + 8'(i0 % 8);
            m1_read = 1'b1; m1_byteenable = 4'hF; m1_address = 8'h47 - 8'(i1 % 8);
            @(negedge clk);
            w = exp_last ? 0 : 1;
            checks++;
            if (m0_waitrequest !== (w != 0) || m1_waitrequest !== (w != 1)) begin
                errors++;
                $display("FAIL contention_grant k=%0d: wait=%b%b, required m%0d granted",
                         k, m0_waitrequest, m1_waitrequest, w);
            end
            checks++;
            if (mem_chipselect !== 1'b1 ||
                mem_address !== ((w == 0) ? m0_address : m1_address)) begin
                errors++;
                $display("FAIL contention_mux k=%0d: cs=%b addr=%h, required m%0d address",
                         k, mem_chipselect, mem_address, w);
            end
            e.due = cyc + 2;
            if (w == 0) begin
                e.data = ref_mem[m0_address];
                q0.push_back(e);
                i0++;
            end else begin
                e.data = ref_mem[m1_address];
                q1.push_back(e);
                i1++;
            end
            exp_last = (w == 1);
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_access: cs=%b wr=%b, required 0 0", mem_chipselect, mem_write);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL contention_drain: left %0d/%0d, required 0/0", q0.size(), q1.size());
        end
        next_cycle();
    endtask

    task automatic test_byte_lanes();
        wr(0, 8'h10, 4'hF, 32'h11223344);
        wr(1, 8'h10, 4'b0101, 32'hAABBCCDD);
        rd(0, 8'h10, 32'h11BB33DD);
        repeat (3) next_cycle();
    endtask

    task automatic test_read_write();
        int v1;
        v1 = vcount1;
        idle_all();
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 8'h30;
        m1_byteenable = 4'hF; m1_writedata = 32'h5A5A1234;
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rw_is_write: wait=%b mem_write=%b, required 0 1",
                     m1_waitrequest, mem_write);
        end
        ref_mem[8'h30] = 32'h5A5A1234;
        exp_last = 1'b1;
        next_cycle();
        idle_all();
        repeat (4) @(negedge clk);
        checks++;
        if (vcount1 != v1) begin
            errors++;
            $display("FAIL rw_no_valid: m1 pulses got %0d, required 0", vcount1 - v1);
        end
        next_cycle();
        rd(1, 8'h30, 32'h5A5A1234);
        repeat (4) @(negedge clk);
        checks++;
        if (vcount1 != v1 + 1) begin
            errors++;
            $display("FAIL rw_readback_count: m1 pulses got %0d, required 1", vcount1 - v1);
        end
        next_cycle();
    endtask

    // m0 read with lock, then m0 write releasing lock, while m1 waits to read.
    task automatic test_lock();
        int   step0, m1_done, own, w, m1_gnt_cycle;
        exp_t e;
        wr(0, 8'h20, 4'hF, 32'h01020304);
        wr(1, 8'h21, 4'hF, 32'h0A0B0C0D);
        step0 = 0; m1_done = 0; own = 0; m1_gnt_cycle = -1;
        for (int k = 1; k <= 6 && (step0 < 2 || m1_done == 0); k++) begin
            idle_all();
            if (step0 == 0) begin
                m0_read = 1'b1; m0_address = 8'h20; m0_byteenable = 4'hF; m0_lock = 1'b1;
            end else if (step0 == 1) begin
                m0_write = 1'b1; m0_address = 8'h20; m0_byteenable = 4'hF;
                m0_writedata = 32'hFEED0020; m0_lock = 1'b0;
            end
            if (m1_done == 0) begin
                m1_read = 1'b1; m1_address = 8'h21; m1_byteenable = 4'hF;
            end
            @(negedge clk);
            if (own == 1) w = (step0 < 2) ? 0 : -1;
            else if (step0 < 2 && m1_done == 0) w = exp_last ? 0 : 1;
            else if (step0 < 2) w = 0;
            else w = 1;
            checks++;
            if (m0_waitrequest !== (w != 0) || m1_waitrequest !== (w != 1)) begin
                errors++;
                $display("FAIL lock_grant k=%0d: wait=%b%b, required winner m%0d",
                         k, m0_waitrequest, m1_waitrequest, w);
            end
            e.due = cyc + 2;
            if (w == 0) begin
                if (step0 == 0) begin
                    e.data = ref_mem[8'h20];
                    q0.push_back(e);
                end else begin
                    ref_mem[8'h20] = 32'hFEED0020;
                end
`ifdef ARB_LOCK_EN
                if (own == 0 && m0_lock) own = 1;
`endif
                step0++;
                exp_last = 1'b0;
            end else if (w == 1) begin
                e.data = ref_mem[8'h21];
                q1.push_back(e);
                m1_done = 1;
                m1_gnt_cycle = k;
                exp_last = 1'b1;
            end
            if (own == 1 && !m0_lock) own = 0;
            next_cycle();
        end
        idle_all();
        checks++;
`ifdef ARB_LOCK_EN
        if (m1_gnt_cycle != 3) begin
            errors++;
            $display("FAIL lock_m1_wait: m1 granted at cycle %0d, required 3", m1_gnt_cycle);
        end
`else
        if (m1_gnt_cycle != 2) begin
            errors++;
            $display("FAIL nolock_rr: m1 granted at cycle %0d, required 2", m1_gnt_cycle);
        end
`endif
        rd(0, 8'h20, 32'hFEED0020);
        repeat (4) next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        exp_last = 1'b1;
        idle_all();
        test_reset();
        test_single();
        test_contention();
        test_byte_lanes();
        test_read_write();
        test_lock();
        for (int k = 0; k < 10 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL final_drain: outstanding %0d/%0d, required 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
